video_in_wb_writer: RTL and testbench

Wishbone burst master that drains the video-input pixel FIFO into frame memory. It waits until the FIFO reports a full packet of NB_PACK words, then writes them as one locked Wishbone bus cycle (cyc held for the whole burst). Addresses are linear inside a frame buffer at FRAME_BASE and wrap at the frame end. It sits directly downstream of the video-input FIFO and drives its read-acknowledge.

---
 rtl/video_in_pkg.sv | 21 ++
 rtl/frame_addr_gen.sv | 50 +++++
 rtl/video_in_wb_writer.sv | 121 ++++++++++++
 tb/tb_video_in_wb_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_in_pkg.sv
// Shared types and defaults for the video-input path (FIFO and Wishbone writer).
package video_in_pkg;

    // Defaults shared with the video-input FIFO instantiation.
    localparam int VIDEO_IN_DATA_SIZE   = 32;
    localparam int VIDEO_IN_NB_PACK     = 16;
    localparam int VIDEO_IN_FRAME_WORDS = 76800;

    // Writer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } wb_wr_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Linear word counter inside one frame buffer. Produces the Wishbone byte
// address of the current word and a one-cycle pulse when a frame completes.
module frame_addr_gen
    import video_in_pkg::*;
#(
    parameter int                  ADR_SIZE    = 32,
    parameter logic [ADR_SIZE-1:0] FRAME_BASE  = '0,
    parameter int                  FRAME_WORDS = VIDEO_IN_FRAME_WORDS
) (
    input  logic                clk,
    input  logic                nRST,
    input  logic                i_advance,
    output logic [ADR_SIZE-1:0] o_adr,
    output logic                o_frame_done
);

    localparam int             WCW       = cnt_width(FRAME_WORDS);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

    logic [WCW-1:0]      r_word_cnt;
    logic                r_frame_done;
    logic                w_last_word;
    logic [ADR_SIZE-1:0] w_offset;

    assign w_last_word = (r_word_cnt == LAST_WORD);

    // Word counter: advance once per acked beat, wrap at the frame end.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_word_cnt <= '0;
        end else if (i_advance) begin
            r_word_cnt <= w_last_word ? '0 : r_word_cnt + WCW'(1);
        end
    end

    // Frame-done pulse: the cycle after the last word of the frame is acked.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= i_advance & w_last_word;
        end
    end

    // Byte address; the sum is truncated to the address width on purpose.
    assign w_offset     = ADR_SIZE'(r_word_cnt) << 2;
    assign o_adr        = FRAME_BASE + w_offset;
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/video_in_wb_writer.sv
// Wishbone burst master draining the video-input FIFO into frame memory.
// A burst of NB_PACK words is written as one locked cycle (cyc held).
// Bus handshake: a beat transfers on a rising edge where wb_stb_o and
// wb_ack_i are both high; address and data stay stable until then.
// Each beat goes LOAD (data settles, previous pop takes effect) then WRITE.
module video_in_wb_writer
    import video_in_pkg::*;
#(
    parameter int                  DATA_SIZE   = VIDEO_IN_DATA_SIZE,
    parameter int                  NB_PACK     = VIDEO_IN_NB_PACK,
    parameter int                  ADR_SIZE    = 32,
    parameter logic [ADR_SIZE-1:0] FRAME_BASE  = '0,
    parameter int                  FRAME_WORDS = VIDEO_IN_FRAME_WORDS
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   enable,
    input  logic [DATA_SIZE-1:0]   fifo_data,
    input  logic                   fifo_nb_pack,
    output logic                   fifo_r_ack,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [DATA_SIZE/8-1:0] wb_sel_o,
    output logic [ADR_SIZE-1:0]    wb_adr_o,
    output logic [DATA_SIZE-1:0]   wb_dat_o,
    input  logic                   wb_ack_i,
    output logic                   frame_done,
    output logic [1:0]             o_dbg_state
);

    localparam int            BW        = cnt_width(NB_PACK);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB_PACK - 1);

    wb_wr_state_t  r_state;
    wb_wr_state_t  w_state_next;
    logic [BW-1:0] r_beat_cnt;
    logic          r_fifo_r_ack;
    logic          w_burst_start;
    logic          w_beat_ack;

    // State register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start on a full packet, alternate LOAD/WRITE per beat,
    // return to IDLE after the last acked beat.
    always_comb begin
        w_state_next  = r_state;
        w_burst_start = 1'b0;
        w_beat_ack    = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && fifo_nb_pack) begin
                    w_state_next  = LOAD;
                    w_burst_start = 1'b1;
                end
            end
            LOAD: begin
                w_state_next = WRITE;
            end
            WRITE: begin
                if (wb_ack_i) begin
                    w_beat_ack   = 1'b1;
                    w_state_next = (r_beat_cnt == LAST_BEAT) ? IDLE : LOAD;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Beat counter: cleared when a burst starts, stepped on every ack.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_beat_cnt <= '0;
        end else if (w_burst_start) begin
            r_beat_cnt <= '0;
        end else if (w_beat_ack) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
        end
    end

    // FIFO pop: one-cycle pulse in the cycle after each ack.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_fifo_r_ack <= 1'b0;
        end else begin
            r_fifo_r_ack <= w_beat_ack;
        end
    end

    frame_addr_gen #(
        .ADR_SIZE    (ADR_SIZE),
        .FRAME_BASE  (FRAME_BASE),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_addr (
        .clk          (clk),
        .nRST         (nRST),
        .i_advance    (w_beat_ack),
        .o_adr        (wb_adr_o),
        .o_frame_done (frame_done)
    );

    // Bus outputs decode straight from the state register, so an
    // asynchronous reset drops them immediately.
    assign wb_cyc_o    = (r_state != IDLE);
    assign wb_stb_o    = (r_state == WRITE);
    assign wb_we_o     = wb_cyc_o;
    assign wb_sel_o    = wb_stb_o ? '1 : '0;
    assign wb_dat_o    = fifo_data;
    assign fifo_r_ack  = r_fifo_r_ack;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_video_in_wb_writer.sv
// Bench for video_in_wb_writer: FIFO model, randomised wait-state slave,
// scoreboard of expected writes derived from frame/packet arithmetic.
module tb_video_in_wb_writer;
  import video_in_pkg::*;

  localparam int DW = 32;
  localparam int NBP = 16;
  localparam int AW = 32;
  localparam int FW = 32;
  localparam logic [AW-1:0] BASE = 32'h0000_0100;
  localparam int MEM_N = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nRST = 1'b1;
  logic enable = 1'b0;
  logic fifo_nb_pack = 1'b0;
  logic wb_ack_i = 1'b0;
  logic [DW-1:0] fifo_data;
  logic fifo_r_ack;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic frame_done;
  logic [1:0] o_dbg_state;

  always #5 clk = ~clk;

  video_in_wb_writer #(
    .DATA_SIZE(DW), .NB_PACK(NBP), .ADR_SIZE(AW),
    .FRAME_BASE(BASE), .FRAME_WORDS(FW)
  ) dut (
    .clk(clk), .nRST(nRST), .enable(enable),
    .fifo_data(fifo_data), .fifo_nb_pack(fifo_nb_pack), .fifo_r_ack(fifo_r_ack),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .frame_done(frame_done), .o_dbg_state(o_dbg_state)
  );

  // ---------------- FIFO model ----------------
  // Read pointer moves on the edge that sees fifo_r_ack; head word follows it.
  logic [DW-1:0] mem [MEM_N];
  int unsigned rd_ptr;
  always @(posedge clk or negedge nRST) begin
    if (!nRST) rd_ptr <= 0;
    else if (fifo_r_ack) rd_ptr <= rd_ptr + 1;
  end
  assign fifo_data = mem[rd_ptr % MEM_N];

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / slave ----------------
  logic [AW+DW-1:0] exp_q[$];
  int exp_idx_q[$];
  int frame_pos = 0;
  int fifo_pos = 0;
  int wait_mode = 0;      // -1: random 0..3 wait states, else fixed count
  int wait_cnt = 0;
  int wait_target = 0;
  bit acked_prev = 0;
  bit fd_exp = 0;
  bit cyc_prev = 0;
  int cycle_no = 0;
  int last_rise = 0;
  int rise_gap = 0;
  int cyc_cycles, rack_pulses, fd_pulses, writes, bursts;

  function automatic int pick_wait();
    return (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
  endfunction

  always @(negedge clk) begin
    cycle_no++;
    if (!nRST) begin
      wb_ack_i = 1'b0;
      exp_q.delete();
      exp_idx_q.delete();
      frame_pos = 0;
      fifo_pos = 0;
      acked_prev = 0;
      fd_exp = 0;
      cyc_prev = 0;
      wait_cnt = 0;
    end else begin
      check("we_eq_cyc", wb_we_o, wb_cyc_o);
      check("sel", wb_sel_o, wb_stb_o ? 4'hF : 4'h0);
      check("fifo_r_ack", fifo_r_ack, acked_prev);
      check("frame_done", frame_done, fd_exp);
      if (fifo_r_ack === 1'b1) rack_pulses++;
      if (frame_done === 1'b1) fd_pulses++;
      if (wb_cyc_o === 1'b1) cyc_cycles++;
      if (wb_cyc_o === 1'b1 && !cyc_prev) begin
        check("q_empty_at_start", exp_q.size(), 0);
        bursts++;
        rise_gap = cycle_no - last_rise;
        last_rise = cycle_no;
        for (int i = 0; i < NBP; i++) begin
          int w;
          w = (frame_pos + i) % FW;
          exp_q.push_back({BASE + AW'(4 * w), mem[(fifo_pos + i) % MEM_N]});
          exp_idx_q.push_back(w);
        end
        frame_pos = (frame_pos + NBP) % FW;
        fifo_pos = fifo_pos + NBP;
        wait_cnt = 0;
        wait_target = pick_wait();
      end
      cyc_prev = (wb_cyc_o === 1'b1);
      acked_prev = 0;
      fd_exp = 0;
      wb_ack_i = 1'b0;
      if (wb_stb_o === 1'b1) begin
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("adr", wb_adr_o, exp_q[0][AW+DW-1:DW]);
          check("dat", wb_dat_o, exp_q[0][DW-1:0]);
          if (wait_cnt >= wait_target) begin
            wb_ack_i = 1'b1;
            acked_prev = 1;
            fd_exp = (exp_idx_q[0] == FW - 1);
            void'(exp_q.pop_front());
            void'(exp_idx_q.pop_front());
            writes++;
            wait_cnt = 0;
            wait_target = pick_wait();
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    cyc_cycles = 0; rack_pulses = 0; fd_pulses = 0; writes = 0; bursts = 0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (!(writes >= target && wb_cyc_o === 1'b0) && n < 2000) begin
      tick();
      n++;
    end
    tick();
    tick();
    check(tag, (writes >= target && wb_cyc_o === 1'b0), 1);
  endtask

  task automatic start_one_burst();
    fifo_nb_pack = 1'b1;
    tick();
    fifo_nb_pack = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < MEM_N; i++) mem[i] = $urandom();
    clear_stats();
    #1 nRST = 1'b0;
    repeat (3) tick();
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_sel", wb_sel_o, 0);
    check("rst_r_ack", fifo_r_ack, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_adr", wb_adr_o, BASE);
    check("rst_state", o_dbg_state, IDLE);
    nRST = 1'b1;
    tick();

    // No packet available: nothing starts.
    clear_stats();
    enable = 1'b1;
    repeat (20) tick();
    check("no_pack_cyc", cyc_cycles, 0);

    // Zero-wait burst, start latency.
    clear_stats();
    wait_mode = 0;
    fifo_nb_pack = 1'b1;
    tick();
    check("lat_load_cyc", wb_cyc_o, 1);
    check("lat_load_stb", wb_stb_o, 0);
    fifo_nb_pack = 1'b0;
    tick();
    check("lat_write_stb", wb_stb_o, 1);
    check("first_adr", wb_adr_o, BASE);
    wait_done(NBP, "burst0_done");
    check("burst0_cyc_cycles", cyc_cycles, 2 * NBP);
    check("burst0_r_ack", rack_pulses, NBP);
    check("burst0_writes", writes, NBP);

    // Three wait states per beat; second half of the frame, wrap.
    clear_stats();
    wait_mode = 3;
    start_one_burst();
    wait_done(NBP, "burst1_done");
    check("burst1_cyc_cycles", cyc_cycles, NBP * 5);
    check("burst1_r_ack", rack_pulses, NBP);
    check("burst1_frame_done", fd_pulses, 1);
    check("burst1_adr_wrapped", wb_adr_o, BASE);

    // Enable dropped mid-burst with random waits.
    clear_stats();
    wait_mode = -1;
    fifo_nb_pack = 1'b1;
    n = 0;
    while (writes < 5 && n < 500) begin tick(); n++; end
    check("reach_beat5", writes >= 5, 1);
    enable = 1'b0;
    wait_done(NBP, "burst2_done");
    repeat (20) tick();
    check("en_drop_bursts", bursts, 1);
    check("en_drop_writes", writes, NBP);
    check("en_drop_idle", o_dbg_state, IDLE);
    check("en_drop_r_ack", rack_pulses, NBP);

    // Back-to-back bursts with packet always available.
    clear_stats();
    wait_mode = 0;
    enable = 1'b1;
    n = 0;
    while (bursts < 2 && n < 500) begin tick(); n++; end
    fifo_nb_pack = 1'b0;
    wait_done(2 * NBP, "b2b_done");
    check("b2b_bursts", bursts, 2);
    check("b2b_period", rise_gap, 2 * NBP + 1);
    check("b2b_frame_done", fd_pulses, 1);

    // Reset in the middle of a burst.
    clear_stats();
    wait_mode = -1;
    start_one_burst();
    n = 0;
    while (!(writes >= 7 && wb_stb_o === 1'b1) && n < 500) begin tick(); n++; end
    check("reach_beat7", writes >= 7, 1);
    nRST = 1'b0;
    #1;
    check("arst_cyc", wb_cyc_o, 0);
    check("arst_stb", wb_stb_o, 0);
    check("arst_r_ack", fifo_r_ack, 0);
    check("arst_adr", wb_adr_o, BASE);
    tick();
    tick();
    nRST = 1'b1;
    tick();
    clear_stats();
    wait_mode = 0;
    start_one_burst();
    tick();
    check("post_rst_adr", wb_adr_o, BASE);
    wait_done(NBP, "post_rst_done");
    check("post_rst_writes", writes, NBP);
    check("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
